// File: rtl/lsu_pkg.sv
// Shared encodings for the load/store alignment unit: FSM states, access sizes,
// exception causes and funct3 values, plus the illegal-encoding decoder.
package lsu_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_B0   = 3'd1,
        ST_R0   = 3'd2,
        ST_B1   = 3'd3,
        ST_R1   = 3'd4,
        ST_FIN  = 3'd5
    } state_t;

    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;
    localparam logic [1:0] SZ_D = 2'd3;

    localparam logic [1:0] EXC_NONE       = 2'd0;
    localparam logic [1:0] EXC_MISALIGNED = 2'd1;
    localparam logic [1:0] EXC_ILLEGAL    = 2'd2;

    localparam logic [2:0] F3_B   = 3'b000;
    localparam logic [2:0] F3_H   = 3'b001;
    localparam logic [2:0] F3_W   = 3'b010;
    localparam logic [2:0] F3_D   = 3'b011;
    localparam logic [2:0] F3_BU  = 3'b100;
    localparam logic [2:0] F3_HU  = 3'b101;
    localparam logic [2:0] F3_WU  = 3'b110;
    localparam logic [2:0] F3_BAD = 3'b111;

    // Encodings that can never be executed on a bus of the given width.
    function automatic logic is_illegal(input logic is_store, input logic [2:0] funct3,
                                        input int data_w);
        logic bad;
        bad = 1'b0;
        if (funct3 == F3_BAD) bad = 1'b1;
        if (is_store && funct3[2]) bad = 1'b1;
        if (data_w == 32 && funct3[1:0] == SZ_D) bad = 1'b1;
        if (data_w == 32 && funct3 == F3_WU) bad = 1'b1;
        return bad;
    endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Combinational lane math: byte-enable generation across two beats, store data
// shifting, and load extraction with sign/zero extension.
module lsu_lane_align
    import lsu_pkg::*;
#(
    parameter int DATA_W = 32,
    localparam int BYTES = DATA_W / 8,
    localparam int OFF_W = $clog2(BYTES)
) (
    input  logic [OFF_W-1:0]  off,
    input  logic [1:0]        size,
    input  logic              is_unsigned,
    input  logic [DATA_W-1:0] wdata,
    input  logic [DATA_W-1:0] rdata0,
    input  logic [DATA_W-1:0] rdata1,
    output logic [BYTES-1:0]  mask0,
    output logic [BYTES-1:0]  mask1,
    output logic              split,
    output logic [DATA_W-1:0] wdata0,
    output logic [DATA_W-1:0] wdata1,
    output logic [DATA_W-1:0] load_data
);

    logic [2*BYTES-1:0]  base_mask;
    logic [2*BYTES-1:0]  full_mask;
    logic [2*DATA_W-1:0] st_shift;
    logic [2*DATA_W-1:0] ld_shift;
    logic [OFF_W+2:0]    bit_off;
    logic                sign_bit;
    int                  nbytes;
    int                  nbits;

    assign bit_off = {off, 3'b000};

    always_comb begin
        nbytes    = 1 << size;
        nbits     = nbytes * 8;
        base_mask = '0;
        for (int i = 0; i < BYTES; i++) begin
            base_mask[i] = (i < nbytes);
        end
        full_mask = base_mask << off;
    end

    // A non-zero upper half means the access crosses into the next beat.
    assign mask0 = full_mask[BYTES-1:0];
    assign mask1 = full_mask[2*BYTES-1:BYTES];
    assign split = |mask1;

    assign st_shift = {{DATA_W{1'b0}}, wdata} << bit_off;
    assign wdata0   = st_shift[DATA_W-1:0];
    assign wdata1   = st_shift[2*DATA_W-1:DATA_W];

    assign ld_shift = {rdata1, rdata0} >> bit_off;

    always_comb begin
        sign_bit = 1'b0;
        for (int i = 0; i < DATA_W; i++) begin
            if (i == nbits - 1) sign_bit = ld_shift[i];
        end
        sign_bit = sign_bit & ~is_unsigned;
        load_data = '0;
        for (int i = 0; i < DATA_W; i++) begin
            load_data[i] = (i < nbits) ? ld_shift[i] : sign_bit;
        end
    end

endmodule

// File: rtl/lsu_mem_align.sv
// Load/store alignment unit between EX/MEM and the data cache. Sequences one or
// two aligned bus beats per request and reports a single done pulse.
module lsu_mem_align
    import lsu_pkg::*;
#(
    parameter int DATA_W             = 32,
    parameter int ADDR_W             = 32,
    parameter bit SUPPORT_MISALIGNED = 1'b1,
    localparam int BYTES = DATA_W / 8,
    localparam int OFF_W = $clog2(BYTES)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_is_store,
    input  logic [2:0]        req_funct3,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    input  logic [4:0]        req_rd,
    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [BYTES-1:0]  mem_wmask,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_resp_valid,
    input  logic [DATA_W-1:0] mem_resp_data,
    output logic              done,
    output logic              wb_we,
    output logic [4:0]        wb_rd,
    output logic [DATA_W-1:0] wb_data,
    output logic              exc,
    output logic [1:0]        exc_cause,
    output state_t            fsm_state
);

    // Handshakes: a transfer happens on a rising edge where valid and ready are
    // both high; valid never waits on ready, and payload stays stable while
    // valid is high and ready is low.

    state_t              state_q, state_d;
    logic                is_store_q;
    logic [1:0]          size_q;
    logic                uns_q;
    logic [4:0]          rd_q;
    logic [ADDR_W-1:0]   base_q;
    logic [OFF_W-1:0]    off_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [DATA_W-1:0]   rdata0_q;
    logic [DATA_W-1:0]   rdata1_q;
    logic                exc_q;
    logic [1:0]          cause_q;

    logic                accept;
    logic [OFF_W-1:0]    req_off;
    logic [OFF_W-1:0]    size_mask;
    logic                req_illegal;
    logic                req_misaligned;
    logic                req_exc;
    logic [1:0]          req_cause;

    logic [BYTES-1:0]    mask0, mask1;
    logic                split;
    logic [DATA_W-1:0]   wdata0, wdata1;
    logic [DATA_W-1:0]   load_data;

    assign fsm_state = state_q;
    assign req_ready = (state_q == ST_IDLE) && !reset;
    assign accept    = req_valid && req_ready;

    // Misalignment is judged against natural alignment of the access size.
    assign req_off        = req_addr[OFF_W-1:0];
    assign size_mask      = OFF_W'((4'd1 << req_funct3[1:0]) - 4'd1);
    assign req_illegal    = is_illegal(req_is_store, req_funct3, DATA_W);
    assign req_misaligned = (req_off & size_mask) != '0;
    assign req_exc        = req_illegal || (req_misaligned && !SUPPORT_MISALIGNED);
    assign req_cause      = req_illegal ? EXC_ILLEGAL : EXC_MISALIGNED;

    lsu_lane_align #(.DATA_W(DATA_W)) u_lane (
        .off         (off_q),
        .size        (size_q),
        .is_unsigned (uns_q),
        .wdata       (wdata_q),
        .rdata0      (rdata0_q),
        .rdata1      (rdata1_q),
        .mask0       (mask0),
        .mask1       (mask1),
        .split       (split),
        .wdata0      (wdata0),
        .wdata1      (wdata1),
        .load_data   (load_data)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            is_store_q <= 1'b0;
            size_q     <= SZ_B;
            uns_q      <= 1'b0;
            rd_q       <= '0;
            base_q     <= '0;
            off_q      <= '0;
            wdata_q    <= '0;
            rdata0_q   <= '0;
            rdata1_q   <= '0;
            exc_q      <= 1'b0;
            cause_q    <= EXC_NONE;
        end else begin
            state_q <= state_d;
            if (accept) begin
                is_store_q <= req_is_store;
                size_q     <= req_funct3[1:0];
                uns_q      <= req_funct3[2];
                rd_q       <= req_rd;
                base_q     <= {req_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
                off_q      <= req_off;
                wdata_q    <= req_wdata;
                rdata0_q   <= '0;
                rdata1_q   <= '0;
                exc_q      <= req_exc;
                cause_q    <= req_exc ? req_cause : EXC_NONE;
            end
            if (state_q == ST_R0 && mem_resp_valid) rdata0_q <= mem_resp_data;
            if (state_q == ST_R1 && mem_resp_valid) rdata1_q <= mem_resp_data;
        end
    end

    always_comb begin
        state_d       = state_q;
        mem_req_valid = 1'b0;
        mem_addr      = '0;
        mem_we        = 1'b0;
        mem_wmask     = '0;
        mem_wdata     = '0;
        done          = 1'b0;
        wb_we         = 1'b0;
        wb_rd         = '0;
        wb_data       = '0;
        exc           = 1'b0;
        exc_cause     = EXC_NONE;
        case (state_q)
            ST_IDLE: begin
                if (accept) state_d = req_exc ? ST_FIN : ST_B0;
            end
            ST_B0: begin
                mem_req_valid = 1'b1;
                mem_addr      = base_q;
                mem_we        = is_store_q;
                mem_wmask     = is_store_q ? mask0 : '0;
                mem_wdata     = is_store_q ? wdata0 : '0;
                if (mem_req_ready) begin
                    if (!is_store_q) state_d = ST_R0;
                    else             state_d = split ? ST_B1 : ST_FIN;
                end
            end
            ST_R0: begin
                if (mem_resp_valid) state_d = split ? ST_B1 : ST_FIN;
            end
            ST_B1: begin
                // Wraps modulo 2^ADDR_W at the top of the address space.
                mem_req_valid = 1'b1;
                mem_addr      = base_q + ADDR_W'(BYTES);
                mem_we        = is_store_q;
                mem_wmask     = is_store_q ? mask1 : '0;
                mem_wdata     = is_store_q ? wdata1 : '0;
                if (mem_req_ready) state_d = is_store_q ? ST_FIN : ST_R1;
            end
            ST_R1: begin
                if (mem_resp_valid) state_d = ST_FIN;
            end
            ST_FIN: begin
                done      = 1'b1;
                wb_rd     = rd_q;
                exc       = exc_q;
                exc_cause = cause_q;
                if (!exc_q && !is_store_q) begin
                    wb_data = load_data;
                    wb_we   = (rd_q != 5'd0);
                end
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_lsu_mem_align.sv
// Directed bench for lsu_mem_align: a vector table of single requests on two
// instances (misaligned support on and off) plus latency, stall and reset sequences.
module tb_lsu_mem_align;
    import lsu_pkg::*;

    typedef struct {
        string       name;
        logic        use_b;
        logic        is_store;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [4:0]  rd;
        logic [31:0] rd0;
        logic [31:0] rd1;
        int          nbeats;
        logic [68:0] b0;
        logic [68:0] b1;
        logic        wb_we;
        logic [31:0] wb_data;
        logic        exc;
        logic [1:0]  cause;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        sel;
    logic        req_valid, req_is_store;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr, req_wdata;
    logic [4:0]  req_rd;
    logic        mem_req_ready, mem_resp_valid;
    logic [31:0] mem_resp_data;

    logic        a_req_ready, a_mem_req_valid, a_mem_we, a_done, a_wb_we, a_exc;
    logic [31:0] a_mem_addr, a_mem_wdata, a_wb_data;
    logic [3:0]  a_mem_wmask;
    logic [4:0]  a_wb_rd;
    logic [1:0]  a_exc_cause;
    state_t      a_state;
    logic        b_req_ready, b_mem_req_valid, b_mem_we, b_done, b_wb_we, b_exc;
    logic [31:0] b_mem_addr, b_mem_wdata, b_wb_data;
    logic [3:0]  b_mem_wmask;
    logic [4:0]  b_wb_rd;
    logic [1:0]  b_exc_cause;
    state_t      b_state;

    logic        o_req_ready, o_mem_req_valid, o_mem_we, o_done, o_wb_we, o_exc;
    logic [31:0] o_mem_addr, o_mem_wdata, o_wb_data;
    logic [3:0]  o_mem_wmask;
    logic [4:0]  o_wb_rd;
    logic [1:0]  o_exc_cause;
    state_t      o_state;

    logic [68:0] exp_q[$];
    vec_t        vt[$];
    int          n_tests = 0;
    int          n_fail = 0;

    always #5 clk = ~clk;

    lsu_mem_align #(.DATA_W(32), .ADDR_W(32), .SUPPORT_MISALIGNED(1'b1)) dut_a (
        .clk(clk), .reset(reset), .req_valid(req_valid & ~sel), .req_ready(a_req_ready),
        .req_is_store(req_is_store), .req_funct3(req_funct3), .req_addr(req_addr),
        .req_wdata(req_wdata), .req_rd(req_rd), .mem_req_valid(a_mem_req_valid),
        .mem_req_ready(mem_req_ready), .mem_addr(a_mem_addr), .mem_we(a_mem_we),
        .mem_wmask(a_mem_wmask), .mem_wdata(a_mem_wdata), .mem_resp_valid(mem_resp_valid),
        .mem_resp_data(mem_resp_data), .done(a_done), .wb_we(a_wb_we), .wb_rd(a_wb_rd),
        .wb_data(a_wb_data), .exc(a_exc), .exc_cause(a_exc_cause), .fsm_state(a_state)
    );

    lsu_mem_align #(.DATA_W(32), .ADDR_W(32), .SUPPORT_MISALIGNED(1'b0)) dut_b (
        .clk(clk), .reset(reset), .req_valid(req_valid & sel), .req_ready(b_req_ready),
        .req_is_store(req_is_store), .req_funct3(req_funct3), .req_addr(req_addr),
        .req_wdata(req_wdata), .req_rd(req_rd), .mem_req_valid(b_mem_req_valid),
        .mem_req_ready(mem_req_ready), .mem_addr(b_mem_addr), .mem_we(b_mem_we),
        .mem_wmask(b_mem_wmask), .mem_wdata(b_mem_wdata), .mem_resp_valid(mem_resp_valid),
        .mem_resp_data(mem_resp_data), .done(b_done), .wb_we(b_wb_we), .wb_rd(b_wb_rd),
        .wb_data(b_wb_data), .exc(b_exc), .exc_cause(b_exc_cause), .fsm_state(b_state)
    );

    assign o_req_ready     = sel ? b_req_ready     : a_req_ready;
    assign o_mem_req_valid = sel ? b_mem_req_valid : a_mem_req_valid;
    assign o_mem_addr      = sel ? b_mem_addr      : a_mem_addr;
    assign o_mem_we        = sel ? b_mem_we        : a_mem_we;
    assign o_mem_wmask     = sel ? b_mem_wmask     : a_mem_wmask;
    assign o_mem_wdata     = sel ? b_mem_wdata     : a_mem_wdata;
    assign o_done          = sel ? b_done          : a_done;
    assign o_wb_we         = sel ? b_wb_we         : a_wb_we;
    assign o_wb_rd         = sel ? b_wb_rd         : a_wb_rd;
    assign o_wb_data       = sel ? b_wb_data       : a_wb_data;
    assign o_exc           = sel ? b_exc           : a_exc;
    assign o_exc_cause     = sel ? b_exc_cause     : a_exc_cause;
    assign o_state         = sel ? b_state         : a_state;

    function automatic logic [68:0] beat(input logic [31:0] a, input logic we,
                                         input logic [3:0] m, input logic [31:0] d);
        return {a, we, m, d};
    endfunction

    function automatic vec_t make_vec(input string name, input logic use_b, input logic st,
        input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] wdata,
        input logic [4:0] rd, input logic [31:0] rd0, input logic [31:0] rd1, input int nbeats,
        input logic [68:0] b0, input logic [68:0] b1, input logic wb_we,
        input logic [31:0] wb_data, input logic exc, input logic [1:0] cause);
        vec_t v;
        v.name = name; v.use_b = use_b; v.is_store = st; v.f3 = f3; v.addr = addr;
        v.wdata = wdata; v.rd = rd; v.rd0 = rd0; v.rd1 = rd1; v.nbeats = nbeats;
        v.b0 = b0; v.b1 = b1; v.wb_we = wb_we; v.wb_data = wb_data; v.exc = exc;
        v.cause = cause;
        return v;
    endfunction

    task automatic check(input string nm, input logic [68:0] act, input logic [68:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic fail_now(input string nm);
        n_tests++;
        n_fail++;
        $display("FAIL %s: event not observed as required", nm);
    endtask

    task automatic wait_ready();
        int cyc;
        cyc = 0;
        while (!o_req_ready && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        if (!o_req_ready) fail_now("ready_timeout");
    endtask

    // Presents one request for one cycle; returns at the first cycle after acceptance.
    task automatic issue(input logic st, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [4:0] rd);
        wait_ready();
        req_is_store = st; req_funct3 = f3; req_addr = addr; req_wdata = wdata; req_rd = rd;
        req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic run_txn(input vec_t v);
        int          cyc;
        int          beats;
        bit          fin;
        logic [68:0] act;
        sel = v.use_b;
        if (v.nbeats > 0) exp_q.push_back(v.b0);
        if (v.nbeats > 1) exp_q.push_back(v.b1);
        issue(v.is_store, v.f3, v.addr, v.wdata, v.rd);
        cyc = 0; beats = 0; fin = 0;
        while (!fin && cyc < 40) begin
            if (o_mem_req_valid) begin
                act = {o_mem_addr, o_mem_we, o_mem_wmask, o_mem_wdata};
                if (!o_mem_we) act[31:0] = '0;
                if (exp_q.size() == 0) fail_now($sformatf("%s_extra_beat", v.name));
                else check($sformatf("%s_beat%0d", v.name, beats), act, exp_q.pop_front());
                beats++;
                @(negedge clk);
                cyc++;
                if (!v.is_store) begin
                    mem_resp_valid = 1'b1;
                    mem_resp_data  = (beats == 1) ? v.rd0 : v.rd1;
                    @(negedge clk);
                    mem_resp_valid = 1'b0;
                    mem_resp_data  = '0;
                    cyc++;
                end
            end else if (o_done) begin
                check($sformatf("%s_result", v.name),
                      69'({o_wb_we, o_wb_rd, o_wb_data, o_exc, o_exc_cause}),
                      69'({v.wb_we, v.rd, v.wb_data, v.exc, v.cause}));
                fin = 1;
                @(negedge clk);
                check($sformatf("%s_pulse", v.name), 69'({o_done, o_req_ready}), 69'(2'b01));
            end else begin
                @(negedge clk);
                cyc++;
            end
        end
        if (!fin) fail_now($sformatf("%s_done_timeout", v.name));
        check($sformatf("%s_nbeats", v.name), 69'(beats), 69'(v.nbeats));
        exp_q.delete();
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [5:0] lat;
        logic       seen;

        reset = 1'b1; sel = 1'b0; req_valid = 1'b0; req_is_store = 1'b0; req_funct3 = '0;
        req_addr = '0; req_wdata = '0; req_rd = '0; mem_req_ready = 1'b1;
        mem_resp_valid = 1'b0; mem_resp_data = '0;

        vt.push_back(make_vec("sb_1003", 0, 1, F3_B, 32'h1003, 32'hAB, 5'd0, 0, 0, 1,
            beat(32'h1000, 1, 4'b1000, 32'hAB000000), '0, 0, 0, 0, EXC_NONE));
        vt.push_back(make_vec("lh_1002", 0, 0, F3_H, 32'h1002, 0, 5'd5, 32'h80011234, 0, 1,
            beat(32'h1000, 0, 0, 0), '0, 1, 32'hFFFF8001, 0, EXC_NONE));
        vt.push_back(make_vec("lhu_1002", 0, 0, F3_HU, 32'h1002, 0, 5'd6, 32'h80011234, 0, 1,
            beat(32'h1000, 0, 0, 0), '0, 1, 32'h00008001, 0, EXC_NONE));
        vt.push_back(make_vec("lw_1003", 0, 0, F3_W, 32'h1003, 0, 5'd7, 32'h44AABBCC,
            32'h99332211, 2, beat(32'h1000, 0, 0, 0), beat(32'h1004, 0, 0, 0), 1,
            32'h33221144, 0, EXC_NONE));
        vt.push_back(make_vec("sw_1006", 0, 1, F3_W, 32'h1006, 32'h11223344, 5'd0, 0, 0, 2,
            beat(32'h1004, 1, 4'b1100, 32'h33440000), beat(32'h1008, 1, 4'b0011, 32'h00001122),
            0, 0, 0, EXC_NONE));
        vt.push_back(make_vec("lb_2001", 0, 0, F3_B, 32'h2001, 0, 5'd1, 32'h0000F000, 0, 1,
            beat(32'h2000, 0, 0, 0), '0, 1, 32'hFFFFFFF0, 0, EXC_NONE));
        vt.push_back(make_vec("lbu_2001", 0, 0, F3_BU, 32'h2001, 0, 5'd2, 32'h0000F000, 0, 1,
            beat(32'h2000, 0, 0, 0), '0, 1, 32'h000000F0, 0, EXC_NONE));
        vt.push_back(make_vec("lw_rd0", 0, 0, F3_W, 32'h3000, 0, 5'd0, 32'h87654321, 0, 1,
            beat(32'h3000, 0, 0, 0), '0, 0, 32'h87654321, 0, EXC_NONE));
        vt.push_back(make_vec("sh_1003", 0, 1, F3_H, 32'h1003, 32'h0000BEEF, 5'd0, 0, 0, 2,
            beat(32'h1000, 1, 4'b1000, 32'hEF000000), beat(32'h1004, 1, 4'b0001, 32'h000000BE),
            0, 0, 0, EXC_NONE));
        vt.push_back(make_vec("lh_1001", 0, 0, F3_H, 32'h1001, 0, 5'd3, 32'h00C3B200, 0, 1,
            beat(32'h1000, 0, 0, 0), '0, 1, 32'hFFFFC3B2, 0, EXC_NONE));
        vt.push_back(make_vec("lw_wrap", 0, 0, F3_W, 32'hFFFFFFFE, 0, 5'd31, 32'h55667788,
            32'hAABBCCDD, 2, beat(32'hFFFFFFFC, 0, 0, 0), beat(32'h00000000, 0, 0, 0), 1,
            32'hCCDD5566, 0, EXC_NONE));
        vt.push_back(make_vec("ld_illegal", 0, 0, F3_D, 32'h1000, 0, 5'd8, 0, 0, 0, '0, '0,
            0, 0, 1, EXC_ILLEGAL));
        vt.push_back(make_vec("sbu_illegal", 0, 1, F3_BU, 32'h1000, 32'h55, 5'd0, 0, 0, 0,
            '0, '0, 0, 0, 1, EXC_ILLEGAL));
        vt.push_back(make_vec("lwu_illegal", 0, 0, F3_WU, 32'h1000, 0, 5'd9, 0, 0, 0, '0, '0,
            0, 0, 1, EXC_ILLEGAL));
        vt.push_back(make_vec("f7_illegal", 0, 0, F3_BAD, 32'h1001, 0, 5'd10, 0, 0, 0, '0, '0,
            0, 0, 1, EXC_ILLEGAL));
        vt.push_back(make_vec("b_lw_mis", 1, 0, F3_W, 32'h1001, 0, 5'd11, 0, 0, 0, '0, '0,
            0, 0, 1, EXC_MISALIGNED));
        vt.push_back(make_vec("b_f7_mis", 1, 0, F3_BAD, 32'h1001, 0, 5'd12, 0, 0, 0, '0, '0,
            0, 0, 1, EXC_ILLEGAL));
        vt.push_back(make_vec("b_lh_ok", 1, 0, F3_H, 32'h1002, 0, 5'd13, 32'h7FFF0000, 0, 1,
            beat(32'h1000, 0, 0, 0), '0, 1, 32'h00007FFF, 0, EXC_NONE));
        vt.push_back(make_vec("b_sh_mis", 1, 1, F3_H, 32'h1003, 32'hBEEF, 5'd0, 0, 0, 0,
            '0, '0, 0, 0, 1, EXC_MISALIGNED));

        // Reset behaviour
        repeat (2) @(negedge clk);
        check("reset_ready_low", 69'({a_req_ready, b_req_ready}), 69'(2'b00));
        reset = 1'b0;
        @(negedge clk);
        check("reset_idle_ctrl", 69'({a_req_ready, a_mem_req_valid, a_done, a_wb_we, a_exc,
              a_exc_cause, a_mem_wmask, a_wb_rd, a_mem_we}), 69'(17'h10000));
        check("reset_idle_data", 69'({a_mem_addr, a_wb_data}), 69'(0));

        foreach (vt[i]) run_txn(vt[i]);
        sel = 1'b0;

        // Store latency: aligned done in cycle 2, split done in cycle 3
        issue(1'b1, F3_B, 32'h1003, 32'hAB, 5'd0);
        lat[3:2] = {o_mem_req_valid, o_done};
        @(negedge clk);
        lat[1:0] = {o_mem_req_valid, o_done};
        check("sb_latency", 69'(lat[3:0]), 69'(4'b1001));
        @(negedge clk);
        issue(1'b1, F3_H, 32'h1003, 32'hBEEF, 5'd0);
        lat[5:4] = {o_mem_req_valid, o_done};
        @(negedge clk);
        lat[3:2] = {o_mem_req_valid, o_done};
        @(negedge clk);
        lat[1:0] = {o_mem_req_valid, o_done};
        check("sh_split_latency", 69'(lat), 69'(6'b101001));
        @(negedge clk);

        // Beat payload held stable under dcache backpressure
        mem_req_ready = 1'b0;
        issue(1'b1, F3_W, 32'h1006, 32'h11223344, 5'd0);
        for (int k = 0; k < 3; k++) begin
            check($sformatf("bp_hold%0d", k),
                  {o_mem_addr, o_mem_we & o_mem_req_valid, o_mem_wmask, o_mem_wdata},
                  beat(32'h1004, 1, 4'b1100, 32'h33440000));
            if (k == 2) mem_req_ready = 1'b1;
            @(negedge clk);
        end
        check("bp_beat1", {o_mem_addr, o_mem_we & o_mem_req_valid, o_mem_wmask, o_mem_wdata},
              beat(32'h1008, 1, 4'b0011, 32'h00001122));
        @(negedge clk);
        check("bp_done", 69'(o_done), 69'(1));
        @(negedge clk);

        // Reset while waiting for read data; the late response must be ignored
        issue(1'b0, F3_W, 32'h4000, 0, 5'd4);
        @(negedge clk);
        check("rst_in_r0", 69'(o_state), 69'(ST_R0));
        reset = 1'b1;
        #1;
        check("rst_ready_low", 69'(o_req_ready), 69'(0));
        @(negedge clk);
        reset = 1'b0;
        mem_resp_valid = 1'b1;
        mem_resp_data  = 32'hDEADBEEF;
        @(negedge clk);
        mem_resp_valid = 1'b0;
        mem_resp_data  = '0;
        check("rst_idle", 69'({o_state, o_req_ready}), 69'({ST_IDLE, 1'b1}));
        seen = 1'b0;
        repeat (4) begin
            seen = seen | o_done;
            @(negedge clk);
        end
        check("rst_no_done", 69'(seen), 69'(0));
        run_txn(make_vec("post_rst_lw", 0, 0, F3_W, 32'h4000, 0, 5'd4, 32'h0BADF00D, 0, 1,
            beat(32'h4000, 0, 0, 0), '0, 1, 32'h0BADF00D, 0, EXC_NONE));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
